// File: rtl/viterbi_decoder_if.sv
// Serial coded-bit input and decoded-bit output bundle for viterbi_decoder.
// Master drives Start/y; slave (the decoder) drives Out/Valid.
interface viterbi_decoder_if;
  logic Start;
  logic y;
  logic Out;
  logic Valid;

  modport master (
    output Start,
    output y,
    input  Out,
    input  Valid
  );

  modport slave (
    input  Start,
    input  y,
    output Out,
    output Valid
  );
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision K=7 rate-1/2 Viterbi decoder (g0=133o, g1=171o), 64 ACS, register exchange.
// Optional decoded-bit counter port DecCnt enabled by `define VITERBI_DEC_CNT_EN.
module viterbi_decoder #(
  parameter int D  = 36,
  parameter int MW = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  viterbi_decoder_if.slave bus
`ifdef VITERBI_DEC_CNT_EN
  ,
  output logic [15:0] DecCnt
`endif
);

  localparam int NS = 64;
  localparam int CW = $clog2(D + 1);
  localparam logic [MW-1:0] PM_INIT = MW'(1 << (MW - 3));
  localparam logic [MW-1:0] PM_MAX  = '1;
  localparam logic [CW-1:0] CNT_SAT = CW'(D);

  typedef enum logic {
    PH_A,
    PH_B
  } phase_t;

  phase_t          r_phase;
  phase_t          w_phase_nxt;
  logic            r_a;
  logic            r_start_d;
  logic [CW-1:0]   r_cnt;
  logic [5:0]      r_best;
  logic [MW-1:0]   r_pm_min;
  logic            r_out;
  logic            r_valid;
  logic [MW-1:0]   r_pm   [NS];
  logic [D-1:0]    r_surv [NS];

  logic [MW-1:0]   w_pm_nxt   [NS];
  logic [D-1:0]    w_surv_nxt [NS];
  logic [5:0]      w_best;
  logic [MW-1:0]   w_min;
  logic            w_restart;
  logic            w_step;
  logic            w_take_a;
  logic            w_emit;

  function automatic logic [1:0] enc(input logic [6:0] v);
    return {^(v & 7'b1011011), ^(v & 7'b1111001)};
  endfunction

  // A rising Start between pairs marks a new frame; a pause mid-pair does not.
  assign w_restart = bus.Start & ~r_start_d & (r_phase == PH_A);
  assign w_take_a  = bus.Start & (r_phase == PH_A);
  assign w_step    = bus.Start & (r_phase == PH_B);
  assign w_emit    = w_step & (r_cnt == CNT_SAT);

  assign bus.Out   = r_out;
  assign bus.Valid = r_valid;

  always_comb begin
    w_phase_nxt = r_phase;
    if (bus.Start) begin
      unique case (r_phase)
        PH_A: w_phase_nxt = PH_B;
        PH_B: w_phase_nxt = PH_A;
      endcase
    end
  end

  always_comb begin
    logic [5:0]  w_ns;
    logic [5:0]  w_p0;
    logic [5:0]  w_p1;
    logic        w_u;
    logic [1:0]  w_e0;
    logic [1:0]  w_e1;
    logic [1:0]  w_bm0;
    logic [1:0]  w_bm1;
    logic [MW:0] w_s0;
    logic [MW:0] w_s1;
    logic [MW:0] w_sel;
    logic [MW:0] w_dif;
    logic        w_pk;
    w_ns  = '0;
    w_p0  = '0;
    w_p1  = '0;
    w_u   = 1'b0;
    w_e0  = '0;
    w_e1  = '0;
    w_bm0 = '0;
    w_bm1 = '0;
    w_s0  = '0;
    w_s1  = '0;
    w_sel = '0;
    w_dif = '0;
    w_pk  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      w_ns  = 6'(i);
      w_u   = w_ns[5];
      w_p0  = {w_ns[4:0], 1'b0};
      w_p1  = {w_ns[4:0], 1'b1};
      w_e0  = enc({w_u, w_p0});
      w_e1  = enc({w_u, w_p1});
      w_bm0 = 2'(r_a ^ w_e0[1]) + 2'(bus.y ^ w_e0[0]);
      w_bm1 = 2'(r_a ^ w_e1[1]) + 2'(bus.y ^ w_e1[0]);
      w_s0  = {1'b0, r_pm[w_p0]} + (MW+1)'(w_bm0);
      w_s1  = {1'b0, r_pm[w_p1]} + (MW+1)'(w_bm1);
      // Ties resolve to the predecessor whose oldest bit is 0.
      w_pk  = (w_s1 < w_s0);
      w_sel = w_pk ? w_s1 : w_s0;
      w_dif = w_sel - {1'b0, r_pm_min};
      w_pm_nxt[i] = (w_dif > {1'b0, PM_MAX}) ? PM_MAX : w_dif[MW-1:0];
      w_surv_nxt[i] = {r_surv[w_pk ? w_p1 : w_p0][D-2:0], w_u};
    end
  end

  always_comb begin
    w_best = '0;
    w_min  = w_pm_nxt[0];
    for (int i = 1; i < NS; i++) begin
      if (w_pm_nxt[i] < w_min) begin
        w_min  = w_pm_nxt[i];
        w_best = 6'(i);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_phase   <= PH_A;
      r_a       <= 1'b0;
      r_start_d <= 1'b0;
      r_cnt     <= '0;
      r_best    <= '0;
      r_pm_min  <= '0;
      r_out     <= 1'b0;
      r_valid   <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        r_pm[i]   <= (i == 0) ? '0 : PM_INIT;
        r_surv[i] <= '0;
      end
    end else begin
      r_phase   <= w_phase_nxt;
      r_start_d <= bus.Start;
      r_valid   <= 1'b0;
      if (w_take_a) begin
        r_a <= bus.y;
      end
      if (w_restart) begin
        r_cnt    <= '0;
        r_best   <= '0;
        r_pm_min <= '0;
        for (int i = 0; i < NS; i++) begin
          r_pm[i]   <= (i == 0) ? '0 : PM_INIT;
          r_surv[i] <= '0;
        end
      end else if (w_step) begin
        r_best   <= w_best;
        r_pm_min <= w_min;
        for (int i = 0; i < NS; i++) begin
          r_pm[i]   <= w_pm_nxt[i];
          r_surv[i] <= w_surv_nxt[i];
        end
        if (w_emit) begin
          r_valid <= 1'b1;
          r_out   <= r_surv[r_best][D-1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef VITERBI_DEC_CNT_EN
  logic [15:0] r_dec_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dec_cnt <= '0;
    end else if (w_restart) begin
      r_dec_cnt <= '0;
    end else if (w_emit) begin
      r_dec_cnt <= r_dec_cnt + 16'd1;
    end
  end

  assign DecCnt = r_dec_cnt;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Bench for viterbi_decoder: encodes info bits with a delay-tap model of the
// K=7 code and expects the decoded stream to equal the info bits.
module tb_viterbi_decoder;
  localparam int D = 36;

  logic Clk = 1'b0;
  logic Reset;
  viterbi_decoder_if bus();
`ifdef VITERBI_DEC_CNT_EN
  logic [15:0] DecCnt;
`endif

  viterbi_decoder #(.D(D), .MW(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
`ifdef VITERBI_DEC_CNT_EN
    ,
    .DecCnt(DecCnt)
`endif
  );

  always #5 Clk = ~Clk;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  logic got[$];
  int gcyc[$];
  int consec = 0;
  logic prev_v = 1'b0;
  bit info[$];
  int flips[$];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (bus.Valid === 1'b1) begin
      got.push_back(bus.Out);
      gcyc.push_back(cyc);
      if (prev_v) consec++;
    end
    prev_v = (bus.Valid === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b);
    @(negedge Clk);
    bus.Start = s;
    bus.y = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  // Tap delays: A = u[k]^u[k-2]^u[k-3]^u[k-5]^u[k-6], B = u[k]^u[k-1]^u[k-2]^u[k-3]^u[k-6]
  function automatic bit xb(input bit x[$], input int k);
    return (k >= 0 && k < x.size()) ? x[k] : 1'b0;
  endfunction

  task automatic run_frame(input string tag, input int pause_pair);
    bit x[$];
    bit c[$];
    int nin;
    int t0;
    int lat;
    bit a;
    bit b;
    nin = info.size();
    x = info;
    repeat (D) x.push_back(1'b0);
    for (int k = 0; k < x.size(); k++) begin
      a = xb(x,k) ^ xb(x,k-2) ^ xb(x,k-3) ^ xb(x,k-5) ^ xb(x,k-6);
      b = xb(x,k) ^ xb(x,k-1) ^ xb(x,k-2) ^ xb(x,k-3) ^ xb(x,k-6);
      c.push_back(a);
      c.push_back(b);
    end
    foreach (flips[f]) c[flips[f]] = ~c[flips[f]];
    got.delete();
    gcyc.delete();
    consec = 0;
    t0 = 0;
    for (int j = 0; j < c.size(); j++) begin
      drive(1'b1, c[j]);
      if (j == 0) t0 = cyc;
      if (pause_pair >= 0 && j == 2 * pause_pair) idle(3);
    end
    idle(4);
    chk({tag, " count"}, got.size(), nin);
    for (int k = 0; k < nin && k < got.size(); k++)
      chk($sformatf("%s bit%0d", tag, k), 32'(got[k]), 32'(info[k]));
    lat = 2 * D + 2 + ((pause_pair >= 0 && pause_pair < D) ? 3 : 0);
    if (got.size() > 0) chk({tag, " latency"}, gcyc[0] - t0, lat);
    chk({tag, " consecutive"}, consec, 0);
`ifdef VITERBI_DEC_CNT_EN
    chk({tag, " deccnt"}, 32'(DecCnt), nin);
`endif
  endtask

  task automatic rand_info(input int n);
    info.delete();
    repeat (n) info.push_back(1'($urandom_range(1, 0)));
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.y = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset out", 32'(bus.Out), 0);
    chk("reset valid", 32'(bus.Valid), 0);
`ifdef VITERBI_DEC_CNT_EN
    chk("reset deccnt", 32'(DecCnt), 0);
`endif
    Reset = 1'b0;
    idle(2);

    info.delete();
    repeat (40) info.push_back(1'b0);
    run_frame("zeros", -1);

    info.delete();
    info.push_back(1'b1);
    repeat (14) info.push_back(1'b0);
    run_frame("impulse", -1);

    flips.push_back(1);
    run_frame("impulse_err", -1);
    flips.delete();

    rand_info(200);
    for (int m = 0; m < 4; m++) flips.push_back(2 * (25 + 50 * m));
    flips.push_back(2 * 130 + 1);
    run_frame("random_err", -1);
    flips.delete();

    rand_info(60);
    run_frame("pause", 10);
    rand_info(40);
    run_frame("restart", -1);

    rand_info(30);
    info[29] = 1'b1;
    run_frame("pre_reset", -1);
    rand_info(50);
    for (int j = 0; j < 43; j++) drive(1'b1, 1'($urandom_range(1, 0)));
    chk("out before reset", 32'(bus.Out), 1);
    Reset = 1'b1;
    #1;
    chk("mid reset out", 32'(bus.Out), 0);
    chk("mid reset valid", 32'(bus.Valid), 0);
`ifdef VITERBI_DEC_CNT_EN
    chk("mid reset deccnt", 32'(DecCnt), 0);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    bus.Start = 1'b0;
    idle(2);
    run_frame("post_reset", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the 802.11a rate-1/2, K=7 convolutional code (g0=133o, g1=171o). It is the receive-side counterpart of the Encoder block.
- Consumes the serial coded stream in Encoder output order, one bit per clock: A (g0) first, then B (g1). Emits one decoded (still scrambled) bit per coded pair, with fixed latency.
- Sits between deinterleaver/depuncture and the descrambler. It uses 64 parallel ACS units and register-exchange survivor memory.

Parameters:
- D, 36, survivor/traceback depth in information bits (decode latency in symbols).
- MW, 8, path-metric width in bits (unsigned).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  qualifies y; high = y valid this cycle.
- y  input  1  serial coded bit (A, then B, alternating).
- Out  output  1  decoded information bit.
- Valid  output  1  one-cycle strobe; Out is valid when high.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- Reset values: Out=0, Valid=0, phase=0, step counter=0, best_state=0, all survivor registers=0.
  - pm[0]=0; pm[1..63]=2^(MW-3), so decoding starts from the encoder's zero state.
- State convention: s[5:0] holds the last 6 input bits, newest in s[5].
  - Input u drives next state {u, s[5:1]}.
  - A = parity({u,s} & 7'b1011011); B = parity({u,s} & 7'b1111001).
- Phase handling:
  - On an edge with Start=1 and phase=0: latch y as A, set phase=1.
  - On an edge with Start=1 and phase=1: y is B; perform one trellis step, set phase=0.
  - Start=0: hold all state; no step, Valid=0.
- Restart: a Start 0->1 transition at the first edge after >=1 idle cycle reinitialises pm, phase, counter and survivors to reset values. The bit on that edge is then taken as A.
- Trellis step (single edge):
  - Branch metric = Hamming distance of {A,B} vs. expected pair, range 0..2.
  - Per next state: two candidates pm[pred]+bm. Pick the smaller; on a tie, pick the predecessor with s[0]=0.
  - Survivor: new_surv = {pred_surv[D-2:0], u}.
  - Normalisation: subtract the registered minimum of the previous step's metrics (pm_min) from all new metrics before storing.
  - Metrics saturate at 2^MW-1; no wrap.
  - best_state <= argmin of the new metrics, lowest index on ties. pm_min is updated with it.
- Output:
  - On the step edge, Out <= surv[best_state][D-1], using the pre-update best_state and survivors.
  - Valid=1 only when steps completed before this edge >= D. Otherwise Valid=0 and Out holds.
  - Result: info bit k appears with Valid at the step edge of pair k+D (0-based).
  - Output rate is one bit per two Start cycles, so Valid is never high on consecutive cycles.
  - The step counter saturates at D.
- Flushing: no tail logic. The upstream source appends D zero pairs to drain the final D bits.
- Reset mid-operation: immediate return to reset values. A partially received pair is discarded.

Optional Feature:
- Macro: VITERBI_DEC_CNT_EN.
- Defined: adds output port DecCnt [15:0], reset 0.
  - Increments on every Valid strobe and wraps at 65535->0.
  - Cleared by the Start restart condition.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
1. Reset, then Start=1 with 2*(40+D) zero bits -> every Valid strobe has Out=0; first Valid at the B edge of pair D (cycle 2D+1 after Start).
2. Impulse: info 1 then zeros, coded pairs 11,01,11,11,00,10,11 then 00 x(D+8) -> first Valid Out=1, all later Out=0.
3. Same impulse with the second coded bit flipped (pair 0 = 10) -> identical decoded output, demonstrating single-error correction.
4. Golden vectors: encoder golden output Out_Encoder.txt (552 bits) plus 2D zero bits -> 276 decoded bits equal Out_Scramble.txt, 0 mismatches.
5. Start deasserted for 3 cycles between A and B of pair 10 -> output sequence and values unchanged; Valid only shifted in time. Start then held low >=1 cycle before a new frame -> metrics reinitialised; first Valid again after D pairs.
6. Reset pulsed mid-frame (after pair 20, phase=1) -> Out=0, Valid=0 immediately; a new frame decodes correctly. With VITERBI_DEC_CNT_EN defined, DecCnt equals the number of Valid strobes and resets to 0.
